// File: rtl/fire_alarm_responder.sv
// fire_alarm_responder: debounced fire-alarm FSM with tone generation, operator silence and event counting.
//
// Ports:
//   CLK1K        in   1 kHz system clock
//   RST          in   synchronous active-high reset
//   FIRE_ALARM   in   registered alarm level from the fire detector
//   ACK          in   operator silence button level, synchronous to CLK1K
//   BUZZER       out  audible tone drive, period 2*TONE_HALF while alarming
//   ALARM_ACTIVE out  high while a confirmed alarm is in effect
//   MUTED        out  high while the alarm is silenced
//   EVENT_CNT    out  saturating count of confirmed alarm entries
//
// Build option: define SILENCE_TIMEOUT_EN to make SILENCED fall back to ALARM
// after SILENCE_CYC cycles; without it no silence counter exists.
module fire_alarm_responder #(
    parameter int CONFIRM_CYC = 8,
    parameter int TONE_HALF   = 250,
    parameter int SILENCE_CYC = 30000
) (
    input  logic       CLK1K,
    input  logic       RST,
    input  logic       FIRE_ALARM,
    input  logic       ACK,
    output logic       BUZZER,
    output logic       ALARM_ACTIVE,
    output logic       MUTED,
    output logic [7:0] EVENT_CNT
);
    typedef enum logic [1:0] {IDLE, CONFIRM, ALARM, SILENCED} state_t;
    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_clr;
    logic [15:0] r_tone;
    logic        r_ack_d;
    logic        r_buzzer;
    logic        r_alarm;
    logic        r_muted;
    logic [7:0]  r_event;
`ifdef SILENCE_TIMEOUT_EN
    logic [15:0] r_sil;
`endif
    logic w_ack_rise;
    logic w_clr_done;
    assign w_ack_rise   = ACK & ~r_ack_d;
    // The low sample seen this edge completes the clear when CONFIRM_CYC-1 lows were already counted.
    assign w_clr_done   = ~FIRE_ALARM && (r_clr == 8'(CONFIRM_CYC - 1));
    assign BUZZER       = r_buzzer;
    assign ALARM_ACTIVE = r_alarm;
    assign MUTED        = r_muted;
    assign EVENT_CNT    = r_event;
    always_ff @(posedge CLK1K) begin
        if (RST) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_clr    <= 8'd0;
            r_tone   <= 16'd0;
            r_ack_d  <= 1'b0;
            r_buzzer <= 1'b0;
            r_alarm  <= 1'b0;
            r_muted  <= 1'b0;
            r_event  <= 8'd0;
`ifdef SILENCE_TIMEOUT_EN
            r_sil    <= 16'd0;
`endif
        end else begin
            r_ack_d <= ACK;
            case (r_state)
                IDLE: begin
                    if (FIRE_ALARM) begin
                        r_state <= CONFIRM;
                        r_cnt   <= 8'd1;
                    end
                end
                CONFIRM: begin
                    if (!FIRE_ALARM) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 8'(CONFIRM_CYC - 1)) begin
                        r_state  <= ALARM;
                        r_alarm  <= 1'b1;
                        r_buzzer <= 1'b1;
                        r_tone   <= 16'd0;
                        r_clr    <= 8'd0;
                        r_event  <= (r_event == 8'hFF) ? r_event : r_event + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ALARM, SILENCED: begin
                    r_clr <= FIRE_ALARM ? 8'd0 : r_clr + 8'd1;
                    // Clear takes priority over both ACK and the silence timeout.
                    if (w_clr_done) begin
                        r_state  <= IDLE;
                        r_clr    <= 8'd0;
                        r_buzzer <= 1'b0;
                        r_muted  <= 1'b0;
                        r_alarm  <= 1'b0;
                    end else if (r_state == ALARM) begin
                        if (w_ack_rise) begin
                            r_state  <= SILENCED;
                            r_buzzer <= 1'b0;
                            r_muted  <= 1'b1;
`ifdef SILENCE_TIMEOUT_EN
                            r_sil    <= 16'd0;
`endif
                        end else if (r_tone == 16'(TONE_HALF - 1)) begin
                            r_tone   <= 16'd0;
                            r_buzzer <= ~r_buzzer;
                        end else begin
                            r_tone <= r_tone + 16'd1;
                        end
                    end
`ifdef SILENCE_TIMEOUT_EN
                    else if (r_sil == 16'(SILENCE_CYC - 1)) begin
                        r_state  <= ALARM;
                        r_buzzer <= 1'b1;
                        r_muted  <= 1'b0;
                        r_tone   <= 16'd0;
                        r_sil    <= 16'd0;
                    end else begin
                        r_sil <= r_sil + 16'd1;
                    end
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fire_alarm_responder.sv
// tb_fire_alarm_responder: randomized scoreboard bench for fire_alarm_responder against a run-length/time-based model.
module tb_fire_alarm_responder;
    localparam int CC = 4;
    localparam int TH = 3;
    localparam int SC = 10;
`ifdef SILENCE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    typedef struct packed {
        logic       buz;
        logic       act;
        logic       mut;
        logic [7:0] ev;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fire = 1'b0;
    logic       ack = 1'b0;
    logic       buzzer;
    logic       alarm_active;
    logic       muted;
    logic [7:0] event_cnt;
    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    logic stim_done = 1'b0;
    // Reference model state: run lengths of high/low samples and entry times.
    logic m_alarm = 1'b0;
    logic m_muted = 1'b0;
    logic m_pa = 1'b0;
    int   m_ev = 0;
    int   hr = 0;
    int   lr = 0;
    int   n = 0;
    int   t_on = 0;
    int   t_mute = 0;
    fire_alarm_responder #(.CONFIRM_CYC(CC), .TONE_HALF(TH), .SILENCE_CYC(SC)) dut (
        .CLK1K(clk),
        .RST(rst),
        .FIRE_ALARM(fire),
        .ACK(ack),
        .BUZZER(buzzer),
        .ALARM_ACTIVE(alarm_active),
        .MUTED(muted),
        .EVENT_CNT(event_cnt)
    );
    always #5 clk = ~clk;
    task automatic step(input logic f, input logic a, input logic r);
        logic rise;
        exp_t e;
        @(negedge clk);
        fire = f;
        ack  = a;
        rst  = r;
        if (r) begin
            m_alarm = 1'b0;
            m_muted = 1'b0;
            m_ev = 0;
            hr = 0;
            lr = 0;
            m_pa = 1'b0;
        end else begin
            rise = a && !m_pa;
            m_pa = a;
            hr = f ? hr + 1 : 0;
            lr = f ? 0 : lr + 1;
            if (!m_alarm) begin
                if (hr == CC) begin
                    m_alarm = 1'b1;
                    m_muted = 1'b0;
                    t_on = n;
                    if (m_ev < 255) m_ev++;
                end
            end else if (lr == CC) begin
                m_alarm = 1'b0;
                m_muted = 1'b0;
            end else if (!m_muted && rise) begin
                m_muted = 1'b1;
                t_mute = n;
            end else if (m_muted && TO_EN && (n - t_mute == SC)) begin
                m_muted = 1'b0;
                t_on = n;
            end
        end
        e.buz = m_alarm && !m_muted && (((n - t_on) / TH) % 2 == 0);
        e.act = m_alarm;
        e.mut = m_muted;
        e.ev  = 8'(m_ev);
        expq.push_back(e);
        n++;
    endtask
    task automatic hold(input logic f, input logic a, input int len);
        for (int i = 0; i < len; i++) step(f, a, 1'b0);
    endtask
    initial begin : stim
        int f;
        int len;
        step(0, 0, 1);
        step(0, 1, 1);
        hold(1, 1, 3);
        hold(0, 0, 3);
        hold(1, 0, 12);
        hold(1, 1, 5);
        hold(1, 0, 2);
        hold(0, 0, 6);
        hold(1, 0, 5);
        hold(1, 1, 1);
        hold(1, 0, 15);
        step(1, 0, 1);
        hold(1, 0, 6);
        hold(0, 0, 5);
        hold(1, 0, 5);
        hold(0, 1, 3);
        hold(0, 0, 2);
        for (int k = 0; k < 120; k++) begin
            f = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++)
                step(f[0], $urandom_range(0, 3) == 0, $urandom_range(0, 150) == 0);
        end
        step(0, 0, 1);
        for (int k = 0; k < 300; k++) begin
            hold(1, 0, CC);
            hold(0, 0, CC);
        end
        hold(1, 0, 8);
        stim_done = 1'b1;
    end
    initial begin : mon
        exp_t e;
        int cyc;
        int wait_cyc;
        cyc = 0;
        wait_cyc = 0;
        while (!stim_done || expq.size() != 0) begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                checks++;
                if ({buzzer, alarm_active, muted, event_cnt} !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got buz=%b act=%b mut=%b ev=%0d, required buz=%b act=%b mut=%b ev=%0d",
                             cyc, buzzer, alarm_active, muted, event_cnt, e.buz, e.act, e.mut, e.ev);
                end
            end
            cyc++;
            if (stim_done) wait_cyc++;
            if (wait_cyc > 20) break;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
